// File: rtl/uart_rx_ctrl.sv
// UART receive controller: line sync, start detection, bit-centre timing and control of an external
// LSB-first SIPO shift register. Parity checking is built in when UART_RX_PARITY_EN is defined.
module uart_rx_ctrl #(
    parameter int unsigned BaudDiv   = 434,
    parameter int unsigned Width     = 8,
    parameter int unsigned ParityOdd = 0
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       rx_i,
    output logic       din_o,
    output logic [1:0] op_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       frame_err_o
`ifdef UART_RX_PARITY_EN
    ,
    output logic       parity_err_o
`endif
);
    localparam int unsigned CntW = $clog2(BaudDiv);
    localparam int unsigned BitW = $clog2(Width + 1);
    localparam int unsigned Half = BaudDiv / 2;

    localparam logic [1:0] OpClear = 2'b00;
    localparam logic [1:0] OpHold  = 2'b01;
    localparam logic [1:0] OpShift = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    if ((BaudDiv < 4) || ((BaudDiv % 2) != 0) || (ParityOdd > 1)) begin : g_param_check
        $error("uart_rx_ctrl: BaudDiv must be even and >= 4, ParityOdd must be 0 or 1");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic              r_rx_m;
    logic              r_rx_s;
    logic              r_rx_q;
    logic [1:0]        r_vld;
    logic              r_armed;
    logic [CntW-1:0]   r_cnt;
    logic [BitW-1:0]   r_bit;
    logic              r_done;
    logic              r_frame_err;
    logic              w_fe;
    logic              w_half;
    logic              w_centre;
    logic              w_last;
`ifdef UART_RX_PARITY_EN
    logic              r_par;
    logic              r_par_bad;
    logic              r_parity_err;
`endif

    // Reset preloads ones; only arm edge detection once a genuine high has reached rx_s.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rx_m  <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_q  <= 1'b1;
            r_vld   <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_rx_m <= rx_i;
            r_rx_s <= r_rx_m;
            r_rx_q <= r_rx_s;
            r_vld  <= {r_vld[0], 1'b1};
            if (r_vld[1] && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_fe     = r_armed & r_rx_q & ~r_rx_s;
    assign w_half   = (r_cnt == CntW'(Half - 1));
    assign w_centre = (r_cnt == CntW'(BaudDiv - 1));
    assign w_last   = (r_bit == BitW'(Width - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (w_fe) w_state_nxt = S_START;
            S_START:  if (w_half) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_RX_PARITY_EN
            S_DATA:   if (w_centre && w_last) w_state_nxt = S_PARITY;
            S_PARITY: if (w_centre) w_state_nxt = S_STOP;
`else
            S_DATA:   if (w_centre && w_last) w_state_nxt = S_STOP;
`endif
            S_STOP:   if (w_centre) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        op_o   = OpHold;
        busy_o = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (w_fe) op_o = OpClear;
            S_DATA:  if (w_centre) op_o = OpShift;
            default: op_o = OpHold;
        endcase
    end

    assign din_o = r_rx_s;

    // Bit timing, bit index, completion pulse and error flags.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt        <= '0;
            r_bit        <= '0;
            r_done       <= 1'b0;
            r_frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            r_par        <= 1'b0;
            r_par_bad    <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_fe) begin
                        r_cnt       <= '0;
                        r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_par        <= 1'b0;
                        r_parity_err <= 1'b0;
`endif
                    end
                end
                S_START: begin
                    if (w_half) begin
                        r_cnt <= '0;
                        r_bit <= '0;
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                S_DATA: begin
                    if (w_centre) begin
                        r_cnt <= '0;
                        r_bit <= r_bit + BitW'(1);
`ifdef UART_RX_PARITY_EN
                        r_par <= r_par ^ r_rx_s;
`endif
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_centre) begin
                        r_cnt     <= '0;
                        r_par_bad <= r_par ^ r_rx_s ^ 1'(ParityOdd);
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_centre) begin
                        r_cnt       <= '0;
                        r_done      <= 1'b1;
                        r_frame_err <= ~r_rx_s;
`ifdef UART_RX_PARITY_EN
                        r_parity_err <= r_par_bad;
`endif
                    end else begin
                        r_cnt <= r_cnt + CntW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign done_o      = r_done;
    assign frame_err_o = r_frame_err;
`ifdef UART_RX_PARITY_EN
    assign parity_err_o = r_parity_err;
`endif

endmodule
